irrigation_zone_scheduler: RTL and testbench
============================================

Name: irrigation_zone_scheduler

Overview:
Sequential, parametrised successor to the single-zone combinational irrigation decision. It serves N_ZONES soil sensors from one shared water box and pump. Zones are watered one at a time in round-robin order, each for a bounded run time, with a cool-down gap between runs. Runs stop early when the soil becomes wet, and a critical water level aborts any run and locks out new ones.

Parameters:
N_ZONES, 4, number of irrigation zones (1..16)
RUN_CYCLES, 1000, maximum valve-open time per run, in clk cycles (>=1, < 2**CNT_W)
COOL_CYCLES, 100, valves-closed gap after every run, in clk cycles (>=1, < 2**CNT_W)
CNT_W, 16, width of the run/cool down-counter
ZW (localparam), max(1, clog2(N_ZONES)), zone index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  scheduler enable
air_umidity  in  1  1 = humid air
temperature  in  1  1 = hot
water_box  in  2  water level: 00 critical, 01 low, 10 medium, 11 high
soil_umidity  in  N_ZONES  per-zone soil wet flag, 1 = wet
sprinkler  out  N_ZONES  per-zone sprinkler valve, registered
drip  out  N_ZONES  per-zone drip valve, registered
active_zone  out  ZW  zone currently watering; 0 when none
busy  out  1  1 in WATER or COOL
water_alarm  out  1  registered (water_box==00), 1-cycle latency
specific  out  1  registered (air_umidity & !temperature), 1-cycle latency

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, ptr=0, counter=0, mode=NONE. All outputs 0.
- Reset has priority over every other event, including mid-WATER; valves are low the cycle after the reset edge.
- Mode decode (combinational, sampled in SCAN):
  - C=(wb==00), L=01, M=10, H=11.
  - SPRINK if !C & (!Ua | (Ua & !T & (H|M))).
  - DRIP if !C & Ua & (T | (!T & L)).
  - Otherwise NONE.
  - SPRINK and DRIP are mutually exclusive by construction. Critical always gives NONE.
- IDLE: go to SCAN when enable=1.
- SCAN: evaluate zone ptr for one cycle.
  - If enable=0, go to IDLE.
  - Else if !soil_umidity[ptr] and mode!=NONE: latch mode and zone=ptr, load counter=RUN_CYCLES-1, go to WATER.
  - Else advance ptr (wrap N_ZONES-1 -> 0) and stay in SCAN.
- WATER: sprinkler[zone] or drip[zone] is 1 according to the latched mode; all other valve bits are 0. Mode is not re-evaluated during a run. Exit to COOL on the first of:
  - counter==0 (natural end, giving exactly RUN_CYCLES valve-high cycles);
  - soil_umidity[zone]=1 (early stop);
  - water_box==00 (abort);
  - enable=0.
  On exit, load counter=COOL_CYCLES-1, advance ptr to zone+1 (wrap), and drive valves 0 from the next cycle.
- Simultaneous exit causes have identical effect; no priority is visible.
- COOL: valves 0, busy=1. Decrement the counter; at counter==0 go to SCAN if enable=1, else IDLE.
- At most one valve bit across sprinkler|drip is 1 in any cycle.
- active_zone is 0 outside WATER.
- Dry zones always start a run when the level is non-critical and mode!=NONE. While water_box==00, SCAN keeps rotating and starts nothing.

Decomposition:
- Package irrigation_pkg holds:
  - water level codes (WB_CRIT/LOW/MED/HIGH);
  - mode encoding (MODE_NONE/SPRINK/DRIP);
  - state encoding (ST_IDLE/SCAN/WATER/COOL).
- One sub-module, irrigation_mode_decode: a purely combinational function (air_umidity, temperature, water_box) -> mode. It is the generalised form of the single-zone decision and is reused by the single-zone controller.
- The scheduler FSM, counter and ptr live in the top module.

Test Plan:
All scenarios use N_ZONES=4, RUN_CYCLES=8, COOL_CYCLES=2.
1. Ua=0, T=0, wb=11, soil=4'b1101, enable=1 -> sprinkler=4'b0010 for exactly 8 cycles with active_zone=1, then 2 cycles all valves 0 (busy=1), then zones 2, 3, 0 are skipped and zone 1 restarts.
2. Ua=1, T=0, wb=01, soil=0000 -> drip runs on zones 0, 1, 2, 3, 0 in order, each 8 cycles, with 2-cycle gaps. sprinkler stays 0000 and specific=1.
3. Ua=1, T=1, wb=10, zone 0 dry; soil[0] rises on the 3rd WATER cycle -> drip[0] falls the next cycle, COOL for 2 cycles, ptr=1.
4. Ua=0, wb=11, zone 2 running; wb goes to 00 mid-run -> valves 0 the next cycle and water_alarm=1. No run starts while wb=00. A run resumes on the first dry zone after wb returns to 11.
5. Reset pulse (rst_n=0 for 1 cycle) in the 4th WATER cycle -> all outputs 0 the next cycle, then IDLE with ptr=0. With enable=1, SCAN restarts at zone 0.
6. Ua=1, T=0, wb=00, all dry -> no valve ever asserts, and specific=1 and water_alarm=1 after 1 cycle. enable=0 during COOL -> go to IDLE after the gap.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation controllers: water level codes, watering mode
// and scheduler state.
package irrigation_pkg;

  localparam logic [1:0] WB_CRIT = 2'b00;
  localparam logic [1:0] WB_LOW  = 2'b01;
  localparam logic [1:0] WB_MED  = 2'b10;
  localparam logic [1:0] WB_HIGH = 2'b11;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_SPRINK = 2'd1,
    MODE_DRIP   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WATER = 2'd2,
    ST_COOL  = 2'd3
  } state_e;

endpackage

// File: rtl/irrigation_mode_decode.sv
// Combinational watering decision from air, temperature and water level.
// Critical water level always yields MODE_NONE.
module irrigation_mode_decode
  import irrigation_pkg::*;
(
  input  logic       air_umidity,
  input  logic       temperature,
  input  logic [1:0] water_box,
  output mode_e      mode
);

  logic crit, low, med_high, do_sprink, do_drip;

  always_comb begin
    crit      = (water_box == WB_CRIT);
    low       = (water_box == WB_LOW);
    med_high  = (water_box == WB_MED) || (water_box == WB_HIGH);
    do_sprink = !crit && (!air_umidity || (!temperature && med_high));
    do_drip   = !crit && air_umidity && (temperature || low);
    mode      = MODE_NONE;
    if (do_sprink) begin
      mode = MODE_SPRINK;
    end else if (do_drip) begin
      mode = MODE_DRIP;
    end
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler: one zone waters at a time for a bounded run,
// followed by a valves-closed cool-down.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned N_ZONES     = 4,
  parameter int unsigned RUN_CYCLES  = 1000,
  parameter int unsigned COOL_CYCLES = 100,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned ZW         = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               air_umidity,
  input  logic               temperature,
  input  logic [1:0]         water_box,
  input  logic [N_ZONES-1:0] soil_umidity,
  output logic [N_ZONES-1:0] sprinkler,
  output logic [N_ZONES-1:0] drip,
  output logic [ZW-1:0]      active_zone,
  output logic               busy,
  output logic               water_alarm,
  output logic               specific
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, cur_mode;
  logic [ZW-1:0]      ptr_q, ptr_d, zone_q, zone_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_ZONES-1:0] sprinkler_d, drip_d, zone_onehot;
  logic               water_exit;

  function automatic logic [ZW-1:0] wrap_inc(input logic [ZW-1:0] z);
    return (z == ZW'(N_ZONES - 1)) ? '0 : z + 1'b1;
  endfunction

  irrigation_mode_decode u_mode_decode (
    .air_umidity (air_umidity),
    .temperature (temperature),
    .water_box   (water_box),
    .mode        (cur_mode)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ptr_d      = ptr_q;
    zone_d     = zone_q;
    cnt_d      = cnt_q;
    // All exit causes share one path so no priority between them is observable.
    water_exit = (cnt_q == '0) || soil_umidity[zone_q] || (water_box == WB_CRIT) || !enable;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!soil_umidity[ptr_q] && (cur_mode != MODE_NONE)) begin
          state_d = ST_WATER;
          mode_d  = cur_mode;
          zone_d  = ptr_q;
          cnt_d   = CNT_W'(RUN_CYCLES - 1);
        end else begin
          ptr_d = wrap_inc(ptr_q);
        end
      end
      ST_WATER: begin
        if (water_exit) begin
          state_d = ST_COOL;
          cnt_d   = CNT_W'(COOL_CYCLES - 1);
          ptr_d   = wrap_inc(zone_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = enable ? ST_SCAN : ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Valves are registered from the next state so they track WATER cycle for cycle.
    zone_onehot = N_ZONES'(1) << zone_d;
    sprinkler_d = '0;
    drip_d      = '0;
    if (state_d == ST_WATER) begin
      if (mode_d == MODE_SPRINK) sprinkler_d = zone_onehot;
      if (mode_d == MODE_DRIP)   drip_d      = zone_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      ptr_q       <= '0;
      zone_q      <= '0;
      cnt_q       <= '0;
      sprinkler   <= '0;
      drip        <= '0;
      water_alarm <= 1'b0;
      specific    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      zone_q      <= zone_d;
      cnt_q       <= cnt_d;
      sprinkler   <= sprinkler_d;
      drip        <= drip_d;
      water_alarm <= (water_box == WB_CRIT);
      specific    <= air_umidity && !temperature;
    end
  end

  assign busy        = (state_q == ST_WATER) || (state_q == ST_COOL);
  assign active_zone = (state_q == ST_WATER) ? zone_q : '0;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Self-checking bench for irrigation_zone_scheduler: a zone-level reference model checked
// every cycle, plus directed scenarios with hand-computed timing.
module tb_irrigation_zone_scheduler;

  localparam int N    = 4;
  localparam int RUN  = 8;
  localparam int COOL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       air_umidity = 1'b0;
  logic       temperature = 1'b0;
  logic [1:0] water_box = 2'b11;
  logic [3:0] soil_umidity = 4'hf;
  logic [3:0] sprinkler, drip;
  logic [1:0] active_zone;
  logic       busy, water_alarm, specific;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  irrigation_zone_scheduler #(
    .N_ZONES     (N),
    .RUN_CYCLES  (RUN),
    .COOL_CYCLES (COOL),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .air_umidity  (air_umidity),
    .temperature  (temperature),
    .water_box    (water_box),
    .soil_umidity (soil_umidity),
    .sprinkler    (sprinkler),
    .drip         (drip),
    .active_zone  (active_zone),
    .busy         (busy),
    .water_alarm  (water_alarm),
    .specific     (specific)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which zone is running and how many run/cool cycles remain.
  int m_zone = -1;  // running zone, -1 when none
  int m_left = 0;   // watering cycles left including the current one
  int m_cool = 0;   // cool cycles left
  int m_ptr  = 0;
  int m_mode = 0;   // 0 none, 1 sprinkler, 2 drip
  bit m_scan = 1'b0;
  bit m_alarm = 1'b0;
  bit m_spec = 1'b0;

  function automatic int mode_of(input logic ua, input logic t, input logic [1:0] wb);
    if (wb == 2'b00) return 0;
    if (!ua) return 1;
    if (t) return 2;
    return (wb == 2'b01) ? 2 : 1;
  endfunction

  task automatic model_step();
    int md;
    if (!rst_n) begin
      m_zone = -1; m_left = 0; m_cool = 0; m_ptr = 0; m_mode = 0;
      m_scan = 1'b0; m_alarm = 1'b0; m_spec = 1'b0;
    end else begin
      m_alarm = (water_box == 2'b00);
      m_spec  = air_umidity && !temperature;
      md      = mode_of(air_umidity, temperature, water_box);
      if (m_zone >= 0) begin
        if (m_left == 1 || soil_umidity[m_zone] || water_box == 2'b00 || !enable) begin
          m_ptr  = (m_zone + 1) % N;
          m_zone = -1;
          m_cool = COOL;
        end else begin
          m_left--;
        end
      end else if (m_cool > 0) begin
        m_cool--;
        if (m_cool == 0) m_scan = enable;
      end else if (m_scan) begin
        if (!enable) begin
          m_scan = 1'b0;
        end else if (!soil_umidity[m_ptr] && md != 0) begin
          m_zone = m_ptr;
          m_left = RUN;
          m_mode = md;
        end else begin
          m_ptr = (m_ptr + 1) % N;
        end
      end else begin
        m_scan = enable;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [3:0] es, ed;
    @(negedge clk);
    if (chk_en) begin
      es = (m_zone >= 0 && m_mode == 1) ? 4'(1 << m_zone) : 4'h0;
      ed = (m_zone >= 0 && m_mode == 2) ? 4'(1 << m_zone) : 4'h0;
      chk("model_sprinkler", 32'(sprinkler), 32'(es));
      chk("model_drip", 32'(drip), 32'(ed));
      chk("model_active_zone", 32'(active_zone), (m_zone >= 0) ? 32'(m_zone) : 32'h0);
      chk("model_busy", 32'(busy), 32'(m_zone >= 0 || m_cool > 0));
      chk("model_water_alarm", 32'(water_alarm), 32'(m_alarm));
      chk("model_specific", 32'(specific), 32'(m_spec));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the first negedge where any valve is open.
  task automatic wait_valve(output int waited);
    waited = 0;
    while ((sprinkler | drip) == 4'h0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("valve_opens", 32'((sprinkler | drip) != 4'h0), 32'h1);
  endtask

  // Called at a negedge with a valve open; counts cycles the valve pattern holds.
  task automatic run_len(output int len);
    logic [3:0] s0, d0;
    s0 = sprinkler;
    d0 = drip;
    len = 0;
    while (sprinkler == s0 && drip == d0 && len < 100) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int w, len;
    logic [3:0] acc;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    chk("reset_sprinkler", 32'(sprinkler), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // 1: sprinkler on zone 1 only, others wet
    air_umidity = 0; temperature = 0; water_box = 2'b11; soil_umidity = 4'b1101; enable = 1;
    wait_valve(w);
    chk("s1_pattern", 32'(sprinkler), 32'h2);
    chk("s1_active", 32'(active_zone), 32'h1);
    run_len(len);
    chk("s1_run_len", 32'(len), 32'd8);
    chk("s1_cool_busy", 32'(busy), 32'h1);
    wait_valve(w);
    chk("s1_gap", 32'(w), 32'd6);
    chk("s1_restart", 32'(sprinkler), 32'h2);

    // 2: drip round robin over all dry zones
    enable = 0; do_reset();
    air_umidity = 1; temperature = 0; water_box = 2'b01; soil_umidity = 4'b0000; enable = 1;
    for (int k = 0; k < 5; k++) begin
      wait_valve(w);
      chk("s2_zone", 32'(drip), 32'(1 << (k % 4)));
      chk("s2_no_sprinkler", 32'(sprinkler), 32'h0);
      chk("s2_specific", 32'(specific), 32'h1);
      run_len(len);
      chk("s2_run_len", 32'(len), 32'd8);
    end

    // 3: early stop when soil of zone 0 gets wet in the 3rd watering cycle
    enable = 0; do_reset();
    air_umidity = 1; temperature = 1; water_box = 2'b10; soil_umidity = 4'b1110; enable = 1;
    wait_valve(w);
    chk("s3_pattern", 32'(drip), 32'h1);
    @(negedge clk);
    @(negedge clk);
    soil_umidity = 4'b1101;
    @(negedge clk);
    chk("s3_stopped", 32'(drip), 32'h0);
    chk("s3_cool_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("s3_cool2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    wait_valve(w);
    chk("s3_next_zone1", 32'(drip), 32'h2);
    chk("s3_gap", 32'(w), 32'd1);

    // 4: critical water aborts a run on zone 2 and blocks new runs
    enable = 0; do_reset();
    air_umidity = 0; temperature = 0; water_box = 2'b11; soil_umidity = 4'b1011; enable = 1;
    wait_valve(w);
    chk("s4_pattern", 32'(sprinkler), 32'h4);
    chk("s4_active", 32'(active_zone), 32'h2);
    @(negedge clk);
    water_box = 2'b00;
    @(negedge clk);
    chk("s4_abort", 32'(sprinkler), 32'h0);
    chk("s4_alarm", 32'(water_alarm), 32'h1);
    acc = 4'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = acc | sprinkler | drip;
    end
    chk("s4_locked_out", 32'(acc), 32'h0);
    water_box = 2'b11;
    wait_valve(w);
    chk("s4_resume", 32'(sprinkler), 32'h4);

    // 5: reset pulse in the 4th watering cycle of zone 3
    enable = 0; do_reset();
    air_umidity = 1; temperature = 0; water_box = 2'b11; soil_umidity = 4'b0111; enable = 1;
    wait_valve(w);
    chk("s5_pattern", 32'(sprinkler), 32'h8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    soil_umidity = 4'b0110;
    @(negedge clk);
    rst_n = 1;
    chk("s5_sprinkler", 32'(sprinkler), 32'h0);
    chk("s5_active", 32'(active_zone), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_specific", 32'(specific), 32'h0);
    wait_valve(w);
    chk("s5_restart_zone0", 32'(sprinkler), 32'h1);
    chk("s5_restart_delay", 32'(w), 32'd2);

    // 6: critical level, all dry; then disable during cool-down
    enable = 0; do_reset();
    air_umidity = 1; temperature = 0; water_box = 2'b00; soil_umidity = 4'b0000; enable = 1;
    @(negedge clk);
    chk("s6_specific", 32'(specific), 32'h1);
    chk("s6_alarm", 32'(water_alarm), 32'h1);
    acc = 4'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = acc | sprinkler | drip;
    end
    chk("s6_no_valve", 32'(acc), 32'h0);
    water_box = 2'b01;
    wait_valve(w);
    run_len(len);
    chk("s6_run_len", 32'(len), 32'd8);
    enable = 0;
    @(negedge clk);
    chk("s6_cool2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("s6_idle", 32'(busy), 32'h0);
    acc = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc = acc | sprinkler | drip;
    end
    chk("s6_stays_idle", 32'(acc), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
